kitchen_curtain_v5: RTL and testbench

Kitchen curtain controller for the smart-home FPGA design. It drives a 4-phase unipolar stepper motor through BD1..BD4 to open or close the kitchen curtain. Travel ends at two IR limit sensors. The target position comes from a local push-button (manual mode) or from the ESP remote link (auto mode). A gas alarm forces the curtain open for ventilation.

---
 rtl/kitchen_curtain_v5.sv | 142 ++++++++++++++
 tb/tb_kitchen_curtain_v5.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/kitchen_curtain_v5.sv
// Kitchen curtain stepper controller: synchronised inputs, debounced push-button,
// gas/auto/manual target selection, and a three-state FSM driving a one-hot 4-phase stepper.
module kitchen_curtain_v5 #(
  parameter int STEP_DIV        = 1,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic CLK_IN,
  input  logic RST_N_IN,
  input  logic PB_IN,
  input  logic SW_MODE_IN,
  input  logic ESP_IN,
  input  logic Gas_SS,
  input  logic IR3_IN,
  input  logic IR4_IN,
  output logic BD1,
  output logic BD2,
  output logic BD3,
  output logic BD4
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OPENING = 2'd1;
  localparam logic [1:0] ST_CLOSING = 2'd2;

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(STEP_DIV - 1);

  // Limit sensors idle high (not reached), so their stages reset to 1.
  localparam logic [5:0] SYNC_RST = 6'b110000;

  logic [5:0] sync1, sync2;
  logic       pb_s, mode_s, esp_s, gas_s, open_lim, closed_lim;

  logic [DBW-1:0] db_cnt;
  logic           pb_db, pb_db_q, press;

  logic [1:0]    rdy;
  logic          tgt, tgt_nxt;
  logic [1:0]    state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [1:0]    ph, ph_nxt;
  logic [3:0]    bd, bd_nxt;
  logic          moving, tick, step;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= {IR4_IN, IR3_IN, Gas_SS, ESP_IN, SW_MODE_IN, PB_IN};
      sync2 <= sync1;
    end
  end

  assign pb_s       = sync2[0];
  assign mode_s     = sync2[1];
  assign esp_s      = sync2[2];
  assign gas_s      = sync2[3];
  assign open_lim   = ~sync2[4];
  assign closed_lim = ~sync2[5];

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      db_cnt  <= '0;
      pb_db   <= 1'b0;
      pb_db_q <= 1'b0;
    end else begin
      pb_db_q <= pb_db;
      if (pb_s != pb_db) begin
        if (db_cnt == DB_LAST) begin
          pb_db  <= pb_s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = pb_db & ~pb_db_q;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    tgt_nxt = tgt;
    if (gas_s)      tgt_nxt = 1'b1;
    else if (mode_s) tgt_nxt = esp_s;
    else if (press) tgt_nxt = ~tgt;
  end

  // Motion is held off until the synchronisers carry real sensor samples after reset.
  always_comb begin
    state_nxt = ST_IDLE;
    if (rdy[1] && !(open_lim && closed_lim)) begin
      if (tgt_nxt) state_nxt = open_lim   ? ST_IDLE : ST_OPENING;
      else         state_nxt = closed_lim ? ST_IDLE : ST_CLOSING;
    end
  end

  assign moving = (state != ST_IDLE);
  assign tick   = moving && (presc == PRESC_LAST);
  // Steps happen only while direction is unchanged; starts, stops and reversals keep ph.
  assign step   = tick && (state_nxt == state);

  always_comb begin
    presc_nxt = '0;
    ph_nxt    = ph;
    bd_nxt    = 4'b0000;
    if (moving && (state_nxt == state) && !tick) presc_nxt = presc + PW'(1);
    if (step) ph_nxt = (state == ST_OPENING) ? ph + 2'd1 : ph - 2'd1;
    if (state_nxt != ST_IDLE) bd_nxt = 4'b0001 << ph_nxt;
  end

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      rdy   <= 2'b00;
      tgt   <= 1'b0;
      state <= ST_IDLE;
      presc <= '0;
      ph    <= 2'd0;
      bd    <= 4'b0000;
    end else begin
      rdy   <= {rdy[0], 1'b1};
      tgt   <= tgt_nxt;
      state <= state_nxt;
      presc <= presc_nxt;
      ph    <= ph_nxt;
      bd    <= bd_nxt;
    end
  end

  assign BD1 = bd[0];
  assign BD2 = bd[1];
  assign BD3 = bd[2];
  assign BD4 = bd[3];

endmodule

// File: tb/tb_kitchen_curtain_v5.sv
// Directed vector bench for kitchen_curtain_v5: per-cycle input/expected-BD table plus
// hand-written reset sequences. A second instance with STEP_DIV=2 is checked during homing.
module tb_kitchen_curtain_v5;

  logic clk = 1'b0;
  logic rst_n, pb, mode, esp, gas, ir3, ir4;
  logic bd1, bd2, bd3, bd4;
  logic sb1, sb2, sb3, sb4;

  always #5 clk = ~clk;

  kitchen_curtain_v5 #(.STEP_DIV(1), .DEBOUNCE_CYCLES(2)) u_dut (
    .CLK_IN(clk), .RST_N_IN(rst_n), .PB_IN(pb), .SW_MODE_IN(mode), .ESP_IN(esp),
    .Gas_SS(gas), .IR3_IN(ir3), .IR4_IN(ir4),
    .BD1(bd1), .BD2(bd2), .BD3(bd3), .BD4(bd4)
  );

  kitchen_curtain_v5 #(.STEP_DIV(2), .DEBOUNCE_CYCLES(2)) u_slow (
    .CLK_IN(clk), .RST_N_IN(rst_n), .PB_IN(pb), .SW_MODE_IN(mode), .ESP_IN(esp),
    .Gas_SS(gas), .IR3_IN(ir3), .IR4_IN(ir4),
    .BD1(sb1), .BD2(sb2), .BD3(sb3), .BD4(sb4)
  );

  // in = {pb, mode, esp, gas, ir3, ir4}; bd = {BD1, BD2, BD3, BD4}
  typedef struct {
    string      tag;
    logic [5:0] in;
    logic [3:0] bd;
    logic       chk_slow;
    logic [3:0] slow_bd;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input string tag, input logic [5:0] in, input logic [3:0] b);
    vec_t v;
    v.tag = tag; v.in = in; v.bd = b; v.chk_slow = 1'b0; v.slow_bd = 4'b0000;
    vecs.push_back(v);
  endtask

  task automatic add_s(input string tag, input logic [5:0] in, input logic [3:0] b,
                       input logic [3:0] sb);
    vec_t v;
    v.tag = tag; v.in = in; v.bd = b; v.chk_slow = 1'b1; v.slow_bd = sb;
    vecs.push_back(v);
  endtask

  function automatic logic [3:0] bd_now();
    return {bd1, bd2, bd3, bd4};
  endfunction

  // Row i is driven on a falling edge, sampled on the next rising edge, checked 1 ns later.
  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      {pb, mode, esp, gas, ir3, ir4} = vecs[i].in;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", vecs[i].tag, i + 1), bd_now(), vecs[i].bd);
      if (vecs[i].chk_slow)
        check($sformatf("%s_div2[%0d]", vecs[i].tag, i + 1), {sb1, sb2, sb3, sb4}, vecs[i].slow_bd);
    end
  endtask

  initial begin
    // Homing after reset, then the closed limit stops it (ph ends at 1).
    add_s("home", 6'b000011, 4'b0000, 4'b0000); add_s("home", 6'b000011, 4'b0000, 4'b0000);
    add_s("home", 6'b000011, 4'b1000, 4'b1000); add_s("home", 6'b000011, 4'b0001, 4'b1000);
    add_s("home", 6'b000011, 4'b0010, 4'b0001); add_s("home", 6'b000011, 4'b0100, 4'b0001);
    add_s("home", 6'b000011, 4'b1000, 4'b0010); add_s("home", 6'b000011, 4'b0001, 4'b0010);
    add_s("climit", 6'b000010, 4'b0010, 4'b0100); add_s("climit", 6'b000010, 4'b0100, 4'b0100);
    add_s("climit", 6'b000010, 4'b0000, 4'b0000); add_s("climit", 6'b000010, 4'b0000, 4'b0000);
    add_s("climit", 6'b000010, 4'b0000, 4'b0000);
    // Manual press opens from ph=1, open limit stops at ph=2.
    for (int k = 0; k < 4; k++) add("man_press", 6'b100010, 4'b0000);
    add("man_open", 6'b000010, 4'b0100); add("man_open", 6'b000011, 4'b0010);
    add("man_open", 6'b000011, 4'b0001); add("man_open", 6'b000011, 4'b1000);
    add("olimit", 6'b000001, 4'b0100); add("olimit", 6'b000001, 4'b0010);
    add("olimit", 6'b000001, 4'b0000); add("olimit", 6'b000001, 4'b0000);
    // Second press closes.
    for (int k = 0; k < 4; k++) add("man_press2", 6'b100001, 4'b0000);
    add("man_close", 6'b000001, 4'b0010); add("man_close", 6'b000011, 4'b0100);
    add("man_close", 6'b000011, 4'b1000); add("man_close", 6'b000011, 4'b0001);
    // Auto mode: ESP open reverses, then ESP close reverses again; presses ignored.
    add("auto_open", 6'b011011, 4'b0010); add("auto_open", 6'b011011, 4'b0100);
    add("auto_open", 6'b011011, 4'b0100); add("auto_open", 6'b011011, 4'b0010);
    add("auto_rev", 6'b010011, 4'b0001); add("auto_rev", 6'b010011, 4'b1000);
    add("auto_pb", 6'b110011, 4'b1000); add("auto_pb", 6'b110011, 4'b0001);
    add("auto_pb", 6'b110011, 4'b0010); add("auto_pb", 6'b110011, 4'b0100);
    add("auto_pb", 6'b010011, 4'b1000); add("auto_pb", 6'b010011, 4'b0001);
    add("auto_pb", 6'b010011, 4'b0010);
    add("auto_cl", 6'b010010, 4'b0100); add("auto_cl", 6'b010010, 4'b1000);
    add("auto_cl", 6'b010010, 4'b0000); add("auto_cl", 6'b010010, 4'b0000);
    // Gas forces open from closed (presses ignored), open limit stops, gas clear closes.
    add("gas", 6'b010110, 4'b0000); add("gas", 6'b110110, 4'b0000);
    add("gas", 6'b110110, 4'b1000); add("gas", 6'b110111, 4'b0100);
    add("gas", 6'b110111, 4'b0010); add("gas", 6'b010111, 4'b0001);
    add("gas_lim", 6'b010101, 4'b1000); add("gas_lim", 6'b010101, 4'b0100);
    add("gas_lim", 6'b010101, 4'b0000); add("gas_lim", 6'b010101, 4'b0000);
    add("gas_clr", 6'b010001, 4'b0000); add("gas_clr", 6'b010001, 4'b0000);
    add("gas_clr", 6'b010001, 4'b0100); add("gas_clr", 6'b010011, 4'b1000);
    // Both limits active: forced idle whatever the request, resume when cleared.
    add("fault", 6'b010000, 4'b0001); add("fault", 6'b010000, 4'b0010);
    for (int k = 0; k < 4; k++) add("fault", 6'b011000, 4'b0000);
    add("fault_clr", 6'b011011, 4'b0000); add("fault_clr", 6'b011011, 4'b0000);
    add("fault_clr", 6'b011011, 4'b0010); add("fault_clr", 6'b011011, 4'b0001);
    add("fault_clr", 6'b011011, 4'b1000);
    // Homing again after the mid-motion reset.
    add("rehome", 6'b000011, 4'b0000); add("rehome", 6'b000011, 4'b0000);
    add("rehome", 6'b000011, 4'b1000); add("rehome", 6'b000011, 4'b0001);

    {pb, mode, esp, gas, ir3, ir4} = 6'b000011;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check("rst_async_init", bd_now(), 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", bd_now(), 4'b0000);
    check("rst_hold_div2", {sb1, sb2, sb3, sb4}, 4'b0000);
    rst_n = 1'b1;

    run(0, 75);

    // Reset pulsed mid-cycle while opening: outputs must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    mode  = 1'b0;
    esp   = 1'b0;
    #1 check("rst_async_motion", bd_now(), 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold2", bd_now(), 4'b0000);
    rst_n = 1'b1;

    run(75, 79);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
